palette_writer: RTL and testbench

//  CPU-side writer for the gate array palette: decodes Z80 I/O writes to the gate array port, holds the pen-select register,
//  and maintains 16 ink entries plus border (5-bit hardware colour each).

---
 rtl/palette_writer.sv | 117 +++++++++++
 tb/tb_palette_writer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/palette_writer.sv
// Gate array palette writer: synchronises Z80 I/O writes, decodes pen select, colour and mode
// functions, and holds 16 ink entries plus border as five 16-bit bit-planes.
module palette_writer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        CLK_n,
    input  logic        RESET,
    input  logic        IORQ_n,
    input  logic        WR_n,
    input  logic        A15,
    input  logic        A14,
    input  logic [7:0]  D,
    output logic [15:0] INKR0,
    output logic [15:0] INKR1,
    output logic [15:0] INKR2,
    output logic [15:0] INKR3,
    output logic [15:0] INKR4,
    output logic [4:0]  BORDER,
    output logic [3:0]  PEN_SEL,
    output logic        BORDER_SEL,
    output logic        MODE_WE,
    output logic [4:0]  MODE_DATA
);

    // Bus word layout: {IORQ_n, WR_n, A15, A14, D[7:0]}
    localparam logic [11:0] BusIdle = {1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    logic [11:0]            sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] valid_q;
    logic [11:0]            bus_s;
    logic [7:0]             d_s;
    logic                   wr_act;
    logic                   primed;
    logic                   accept;
    logic                   unused_d5;

    logic                   wr_prev_q;
    logic [4:0][15:0]       plane_q;
    logic [4:0]             border_q;
    logic [3:0]             pen_q;
    logic                   bsel_q;
    logic                   mode_we_q;
    logic [4:0]             mode_data_q;

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= BusIdle;
            end
            valid_q <= '0;
        end else begin
            sync_q[0] <= {IORQ_n, WR_n, A15, A14, D};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign bus_s     = sync_q[SYNC_STAGES-1];
    assign d_s       = bus_s[7:0];
    assign unused_d5 = d_s[5];
    assign wr_act    = !bus_s[11] && !bus_s[10] && !bus_s[9] && bus_s[8];
    // Until the pipeline holds post-reset samples, the edge history stays pinned active so a
    // write held across reset release never produces an accept.
    assign primed    = valid_q[SYNC_STAGES-1];
    assign accept    = primed && wr_act && !wr_prev_q;

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            wr_prev_q   <= 1'b1;
            plane_q     <= '0;
            border_q    <= '0;
            pen_q       <= '0;
            bsel_q      <= 1'b0;
            mode_we_q   <= 1'b0;
            mode_data_q <= '0;
        end else begin
            wr_prev_q <= primed ? wr_act : 1'b1;
            mode_we_q <= 1'b0;
            if (accept) begin
                case (d_s[7:6])
                    2'b00: begin
                        bsel_q <= d_s[4];
                        pen_q  <= d_s[3:0];
                    end
                    2'b01: begin
                        if (bsel_q) begin
                            border_q <= d_s[4:0];
                        end else begin
                            for (int n = 0; n < 5; n++) begin
                                plane_q[n][pen_q] <= d_s[n];
                            end
                        end
                    end
                    2'b10: begin
                        mode_data_q <= d_s[4:0];
                        mode_we_q   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign INKR0      = plane_q[0];
    assign INKR1      = plane_q[1];
    assign INKR2      = plane_q[2];
    assign INKR3      = plane_q[3];
    assign INKR4      = plane_q[4];
    assign BORDER     = border_q;
    assign PEN_SEL    = pen_q;
    assign BORDER_SEL = bsel_q;
    assign MODE_WE    = mode_we_q;
    assign MODE_DATA  = mode_data_q;

endmodule

// File: tb/tb_palette_writer.sv
// Bench for palette_writer: vector table, directed corner sequences and randomized writes
// against a per-pen colour array model.
module tb_palette_writer;

    logic        CLK_n = 1'b0;
    logic        RESET = 1'b1;
    logic        IORQ_n = 1'b1;
    logic        WR_n = 1'b1;
    logic        A15 = 1'b1;
    logic        A14 = 1'b0;
    logic [7:0]  D = 8'h00;
    logic [15:0] INKR0, INKR1, INKR2, INKR3, INKR4;
    logic [4:0]  BORDER;
    logic [3:0]  PEN_SEL;
    logic        BORDER_SEL;
    logic        MODE_WE;
    logic [4:0]  MODE_DATA;

    palette_writer #(.SYNC_STAGES(2)) dut (
        .CLK_n(CLK_n), .RESET(RESET), .IORQ_n(IORQ_n), .WR_n(WR_n), .A15(A15), .A14(A14),
        .D(D), .INKR0(INKR0), .INKR1(INKR1), .INKR2(INKR2), .INKR3(INKR3), .INKR4(INKR4),
        .BORDER(BORDER), .PEN_SEL(PEN_SEL), .BORDER_SEL(BORDER_SEL), .MODE_WE(MODE_WE),
        .MODE_DATA(MODE_DATA)
    );

    always #5 CLK_n = ~CLK_n;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: one 5-bit colour per pen
    logic [4:0] m_ink [16];
    logic [4:0] m_border;
    logic [3:0] m_pen;
    logic       m_bsel;
    logic [4:0] m_md;

    typedef struct {
        logic [7:0] d;
        logic [3:0] pen;
        logic       bsel;
        logic [4:0] border;
        logic [4:0] md;
        int         we;
    } vec_t;

    vec_t tbl [11];

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ink[i] = 5'h00;
        m_border = 5'h00;
        m_pen = 4'h0;
        m_bsel = 1'b0;
        m_md = 5'h00;
    endtask

    function automatic int model_write(logic [7:0] d, logic a15, logic a14);
        int fn;
        if (a15 || !a14) return 0;
        fn = int'(d[7:6]);
        if (fn == 0) begin
            m_bsel = d[4];
            m_pen = d[3:0];
        end else if (fn == 1) begin
            if (m_bsel) m_border = d[4:0];
            else m_ink[m_pen] = d[4:0];
        end else if (fn == 2) begin
            m_md = d[4:0];
            return 1;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    function automatic logic [4:0] pen_colour(int p);
        return {INKR4[p], INKR3[p], INKR2[p], INKR1[p], INKR0[p]};
    endfunction

    task automatic check_state();
        logic [15:0] got [5];
        logic [15:0] exp;
        got = '{INKR0, INKR1, INKR2, INKR3, INKR4};
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 16; i++) exp[i] = m_ink[i][n];
            check($sformatf("inkr%0d", n), 32'(got[n]), 32'(exp));
        end
        check("border", 32'(BORDER), 32'(m_border));
        check("pen_sel", 32'(PEN_SEL), 32'(m_pen));
        check("border_sel", 32'(BORDER_SEL), 32'(m_bsel));
        check("mode_data", 32'(MODE_DATA), 32'(m_md));
    endtask

    // Drives one I/O cycle starting just after a falling edge; counts MODE_WE cycles seen.
    task automatic io_write(input logic [7:0] d, input logic a15, input logic a14,
                            input int hold, input int idle, output int we_cnt);
        we_cnt = 0;
        D = d; A15 = a15; A14 = a14; IORQ_n = 1'b0; WR_n = 1'b0;
        repeat (hold) begin
            @(negedge CLK_n);
            if (MODE_WE) we_cnt++;
        end
        IORQ_n = 1'b1; WR_n = 1'b1;
        repeat (idle) begin
            @(negedge CLK_n);
            if (MODE_WE) we_cnt++;
        end
    endtask

    task automatic do_write(input logic [7:0] d, input logic a15, input logic a14,
                            input int hold, input int idle);
        int cnt;
        int exp;
        io_write(d, a15, a14, hold, idle, cnt);
        exp = model_write(d, a15, a14);
        check($sformatf("mode_we_count d=%02h", d), 32'(cnt), 32'(exp));
        check_state();
    endtask

    initial begin
        int cnt;
        int hold;
        int idle;
        int sel;
        logic [7:0] d;
        logic [7:0] x;

        tbl[0]  = '{8'h03, 4'd3,  1'b0, 5'h00, 5'h00, 0};
        tbl[1]  = '{8'h54, 4'd3,  1'b0, 5'h00, 5'h00, 0};
        tbl[2]  = '{8'h10, 4'd0,  1'b1, 5'h00, 5'h00, 0};
        tbl[3]  = '{8'h4B, 4'd0,  1'b1, 5'h0B, 5'h00, 0};
        tbl[4]  = '{8'h05, 4'd5,  1'b0, 5'h0B, 5'h00, 0};
        tbl[5]  = '{8'h41, 4'd5,  1'b0, 5'h0B, 5'h00, 0};
        tbl[6]  = '{8'h8D, 4'd5,  1'b0, 5'h0B, 5'h0D, 1};
        tbl[7]  = '{8'hC7, 4'd5,  1'b0, 5'h0B, 5'h0D, 0};
        tbl[8]  = '{8'h2A, 4'd10, 1'b0, 5'h0B, 5'h0D, 0};
        tbl[9]  = '{8'h7F, 4'd10, 1'b0, 5'h0B, 5'h0D, 0};
        tbl[10] = '{8'hB3, 4'd10, 1'b0, 5'h0B, 5'h13, 1};

        model_reset();
        repeat (3) @(negedge CLK_n);
        RESET = 1'b0;
        @(negedge CLK_n);
        check("reset_mode_we", 32'(MODE_WE), 32'd0);
        check_state();

        for (int i = 0; i < 11; i++) begin
            io_write(tbl[i].d, 1'b0, 1'b1, 3, 5, cnt);
            void'(model_write(tbl[i].d, 1'b0, 1'b1));
            check($sformatf("tbl%0d_we", i), 32'(cnt), 32'(tbl[i].we));
            check($sformatf("tbl%0d_pen", i), 32'(PEN_SEL), 32'(tbl[i].pen));
            check($sformatf("tbl%0d_bsel", i), 32'(BORDER_SEL), 32'(tbl[i].bsel));
            check($sformatf("tbl%0d_border", i), 32'(BORDER), 32'(tbl[i].border));
            check($sformatf("tbl%0d_md", i), 32'(MODE_DATA), 32'(tbl[i].md));
            check_state();
        end
        // pen3=0x14, pen5=0x01, pen10=0x1F
        check("planes_inkr0", 32'(INKR0), 32'h0420);
        check("planes_inkr1", 32'(INKR1), 32'h0400);
        check("planes_inkr2", 32'(INKR2), 32'h0408);
        check("planes_inkr3", 32'(INKR3), 32'h0400);
        check("planes_inkr4", 32'(INKR4), 32'h0408);

        // Long held cycle gives one accept; deselected address gives none
        do_write(8'h00, 1'b0, 1'b1, 3, 5);
        io_write(8'h4F, 1'b0, 1'b1, 20, 5, cnt);
        void'(model_write(8'h4F, 1'b0, 1'b1));
        check("long_hold_pen0", 32'(pen_colour(0)), 32'h0F);
        check_state();
        do_write(8'h41, 1'b1, 1'b1, 4, 5);
        do_write(8'h41, 1'b0, 1'b0, 4, 5);
        check("deselected_pen0", 32'(pen_colour(0)), 32'h0F);

        // One-cycle gap between two active spans produces two accepts
        D = 8'h81; A15 = 1'b0; A14 = 1'b1; IORQ_n = 1'b0; WR_n = 1'b0;
        cnt = 0;
        repeat (3) begin @(negedge CLK_n); if (MODE_WE) cnt++; end
        IORQ_n = 1'b1;
        @(negedge CLK_n); if (MODE_WE) cnt++;
        IORQ_n = 1'b0;
        repeat (3) begin @(negedge CLK_n); if (MODE_WE) cnt++; end
        IORQ_n = 1'b1; WR_n = 1'b1;
        repeat (6) begin @(negedge CLK_n); if (MODE_WE) cnt++; end
        void'(model_write(8'h81, 1'b0, 1'b1));
        void'(model_write(8'h81, 1'b0, 1'b1));
        check("glitch_two_accepts", 32'(cnt), 32'd2);
        check_state();

        // Reset during an active write, released while still active
        do_write(8'h00, 1'b0, 1'b1, 3, 5);
        D = 8'h5F; A15 = 1'b0; A14 = 1'b1; IORQ_n = 1'b0; WR_n = 1'b0;
        @(negedge CLK_n);
        RESET = 1'b1;
        repeat (3) @(negedge CLK_n);
        RESET = 1'b0;
        cnt = 0;
        repeat (8) begin @(negedge CLK_n); if (MODE_WE) cnt++; end
        IORQ_n = 1'b1; WR_n = 1'b1;
        repeat (5) @(negedge CLK_n);
        model_reset();
        check("reset_held_pen0", 32'(pen_colour(0)), 32'h00);
        check("reset_held_we", 32'(cnt), 32'd0);
        check_state();
        do_write(8'h5F, 1'b0, 1'b1, 3, 5);
        check("fresh_after_reset_pen0", 32'(pen_colour(0)), 32'h1F);

        // Every pen, colour = pen ^ 0x1A, D[5] set on odd pens
        for (int p = 0; p < 16; p++) begin
            x = (p % 2 == 1) ? 8'h20 : 8'h00;
            do_write(8'(p) | x, 1'b0, 1'b1, 2, 4);
            do_write(8'h40 | (8'(p ^ 32'h1A) & 8'h1F) | x, 1'b0, 1'b1, 2, 4);
        end
        for (int p = 0; p < 16; p++) begin
            check($sformatf("loop_pen%0d", p), 32'(pen_colour(p)), 32'((p ^ 32'h1A) & 32'h1F));
        end

        for (int k = 0; k < 150; k++) begin
            d = 8'($urandom);
            sel = int'($urandom_range(0, 7));
            hold = int'($urandom_range(1, 6));
            idle = int'($urandom_range(4, 6));
            do_write(d, sel == 0, sel != 1, hold, idle);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
